card_counter: RTL and testbench

Downstream consumer of the CNN's final fully-connected layer (53 class scores: 52 cards plus background). On a start pulse it scans the layer-4 output memory, takes the argmax class, and maps the detected card to its Hi-Lo weight. It then updates a debounced blackjack running count that software reads over the same chipselect/read/write peripheral bus as the CNN.

---
 rtl/cnn_pkg.sv | 26 ++
 rtl/hilo_map.sv | 26 ++
 rtl/card_counter.sv | 183 ++++++++++++++++++
 tb/tb_card_counter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants, FSM state encoding and register map for the CNN
// post-processing blocks.
package cnn_pkg;

    localparam int unsigned N_CLASSES  = 53;
    localparam int unsigned BG_CLASS   = 52;
    localparam int unsigned ADDR_BITS  = 6;
    localparam int unsigned SCORE_W    = 8;
    localparam int unsigned BUS_W      = 8;
    localparam int unsigned REG_ADDR_W = 2;

    localparam logic signed [SCORE_W-1:0] MIN_SCORE = 8'sd16;

    localparam logic [REG_ADDR_W-1:0] REG_COUNT  = 2'd0;
    localparam logic [REG_ADDR_W-1:0] REG_LAST   = 2'd1;
    localparam logic [REG_ADDR_W-1:0] REG_SEEN   = 2'd2;
    localparam logic [REG_ADDR_W-1:0] REG_STATUS = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        DRAIN  = 2'd2,
        UPDATE = 2'd3
    } state_t;

endpackage

// File: rtl/hilo_map.sv
// Hi-Lo card-counting weight for a class index.
// Classes are suit-major, so rank = cls mod 13 (0=Ace .. 12=King).
// Ports:
//   cls    in  class index 0..52
//   weight out signed weight: +1 for 2-6, 0 for 7-9, -1 for 10/J/Q/K/A
module hilo_map
    import cnn_pkg::*;
(
    input  logic [ADDR_BITS-1:0] cls,
    output logic signed [1:0]    weight
);

    logic [ADDR_BITS-1:0] rank;

    // Rank decode and weight lookup
    always_comb begin
        rank   = cls % ADDR_BITS'(13);
        weight = -2'sd1;
        if (rank >= ADDR_BITS'(1) && rank <= ADDR_BITS'(5)) begin
            weight = 2'sd1;
        end else if (rank >= ADDR_BITS'(6) && rank <= ADDR_BITS'(8)) begin
            weight = 2'sd0;
        end
    end

endmodule

// File: rtl/card_counter.sv
// Scans the final-layer class scores, takes the argmax card and keeps a
// debounced Hi-Lo running count readable over the peripheral bus.
// Optional feature: define CARD_COUNTER_CONF_EN to treat a winner whose
// score is below MIN_SCORE as background.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start               one-cycle pulse: class scores are ready
//   mem_addr / mem_data score memory read port (1-cycle read latency)
//   busy / done         busy during scan/update; done pulses when registers update
//   chipselect, read, write, address, writedata, readdata
//                       register bus: 0 count, 1 last class, 2 cards seen,
//                       3 {6'b0, busy, frame_valid}; write to 0 clears
module card_counter
    import cnn_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic [ADDR_BITS-1:0]      mem_addr,
    input  logic signed [SCORE_W-1:0] mem_data,
    output logic                      busy,
    output logic                      done,
    input  logic                      chipselect,
    input  logic                      read,
    input  logic                      write,
    input  logic [REG_ADDR_W-1:0]     address,
    input  logic [BUS_W-1:0]          writedata,
    output logic [BUS_W-1:0]          readdata
);

    localparam logic [ADDR_BITS-1:0] BG_IDX   = ADDR_BITS'(BG_CLASS);
    localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(N_CLASSES - 1);

    state_t                     state, state_nxt;
    logic [ADDR_BITS-1:0]       addr_nxt;
    logic                       busy_nxt, done_nxt;
    logic [BUS_W-1:0]           readdata_nxt;
    logic signed [BUS_W-1:0]    count, count_nxt;
    logic [ADDR_BITS-1:0]       last_cls, last_nxt;
    logic [BUS_W-1:0]           seen, seen_nxt;
    logic                       frame_valid, fv_nxt;
    logic signed [SCORE_W-1:0]  best_score, best_score_nxt;
    logic [ADDR_BITS-1:0]       best_idx, best_idx_nxt;
    logic [ADDR_BITS-1:0]       winner;
    logic signed [1:0]          weight;
    logic signed [BUS_W:0]      sum;
    logic                       clear;
    logic                       unused_wdata;

    // Any write data clears; only the strobe matters
    assign unused_wdata = ^writedata;
    assign clear = chipselect && write && (address == REG_COUNT);

    // Winner selection, optionally demoting low-confidence results to background
    always_comb begin
`ifdef CARD_COUNTER_CONF_EN
        winner = (best_score < MIN_SCORE) ? BG_IDX : best_idx;
`else
        winner = best_idx;
`endif
    end

    hilo_map u_hilo_map (
        .cls    (winner),
        .weight (weight)
    );

    // Next-state and datapath
    always_comb begin
        state_nxt      = state;
        addr_nxt       = mem_addr;
        done_nxt       = 1'b0;
        readdata_nxt   = readdata;
        count_nxt      = count;
        last_nxt       = last_cls;
        seen_nxt       = seen;
        fv_nxt         = frame_valid;
        best_score_nxt = best_score;
        best_idx_nxt   = best_idx;
        sum            = (BUS_W+1)'(count) + (BUS_W+1)'(weight);

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SCAN;
                    addr_nxt  = '0;
                end
            end
            SCAN: begin
                if (mem_addr == LAST_IDX) begin
                    state_nxt = DRAIN;
                    addr_nxt  = '0;
                end else begin
                    addr_nxt = mem_addr + ADDR_BITS'(1);
                end
                // mem_data holds the score of mem_addr-1; nothing valid yet at address 0
                if (mem_addr == ADDR_BITS'(1)) begin
                    best_score_nxt = mem_data;
                    best_idx_nxt   = '0;
                end else if (mem_addr != '0 && mem_data > best_score) begin
                    best_score_nxt = mem_data;
                    best_idx_nxt   = mem_addr - ADDR_BITS'(1);
                end
            end
            DRAIN: begin
                state_nxt = UPDATE;
                if (mem_data > best_score) begin
                    best_score_nxt = mem_data;
                    best_idx_nxt   = LAST_IDX;
                end
            end
            UPDATE: begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
                fv_nxt    = 1'b1;
                if (winner == BG_IDX) begin
                    last_nxt = BG_IDX;
                end else if (winner != last_cls) begin
                    if (sum > 9'sd127) begin
                        count_nxt = 8'sd127;
                    end else if (sum < -9'sd128) begin
                        count_nxt = -8'sd128;
                    end else begin
                        count_nxt = sum[BUS_W-1:0];
                    end
                    seen_nxt = (seen == 8'hFF) ? seen : seen + 8'd1;
                    last_nxt = winner;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A clear overrides any update landing in the same cycle
        if (clear) begin
            count_nxt = '0;
            seen_nxt  = '0;
            last_nxt  = BG_IDX;
            fv_nxt    = 1'b0;
        end

        busy_nxt = (state_nxt != IDLE);

        if (chipselect && read) begin
            case (address)
                REG_COUNT:  readdata_nxt = count;
                REG_LAST:   readdata_nxt = BUS_W'(last_cls);
                REG_SEEN:   readdata_nxt = seen;
                REG_STATUS: readdata_nxt = {6'b0, busy, frame_valid};
                default:    readdata_nxt = '0;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            mem_addr    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            readdata    <= '0;
            count       <= '0;
            last_cls    <= BG_IDX;
            seen        <= '0;
            frame_valid <= 1'b0;
            best_score  <= '0;
            best_idx    <= '0;
        end else begin
            state       <= state_nxt;
            mem_addr    <= addr_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            readdata    <= readdata_nxt;
            count       <= count_nxt;
            last_cls    <= last_nxt;
            seen        <= seen_nxt;
            frame_valid <= fv_nxt;
            best_score  <= best_score_nxt;
            best_idx    <= best_idx_nxt;
        end
    end

endmodule

// File: tb/tb_card_counter.sv
// Directed self-checking bench for card_counter with a score-memory model
// and a scoreboard of expected register reads.
module tb_card_counter;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [5:0]        mem_addr;
    logic signed [7:0] mem_data = 8'sd0;
    logic              busy;
    logic              done;
    logic              chipselect = 1'b0;
    logic              read = 1'b0;
    logic              write = 1'b0;
    logic [1:0]        address = 2'd0;
    logic [7:0]        writedata = 8'd0;
    logic [7:0]        readdata;

    logic signed [7:0] mem [0:52];

    int   checks = 0;
    int   errors = 0;
    logic [7:0] exp_q [$];
    string      tag_q [$];

    card_counter dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .busy       (busy),
        .done       (done),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata)
    );

    always #5 clk = ~clk;

    // Registered-read score memory
    always @(posedge clk) mem_data <= (mem_addr < 6'd53) ? mem[mem_addr] : 8'sd0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_frame(input int base, input int c1, input int v1, input int c2, input int v2);
        for (int i = 0; i < 53; i++) mem[i] = 8'(base);
        if (c1 >= 0) mem[c1] = 8'(v1);
        if (c2 >= 0) mem[c2] = 8'(v2);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(posedge clk); #1;
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic push_exp(input string tag, input int val);
        logic [7:0] e;
        e = val[7:0];
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Read one register and compare against the oldest scoreboard entry
    task automatic read_check(input logic [1:0] a);
        logic [7:0] e;
        string t;
        chipselect = 1'b1; read = 1'b1; address = a;
        @(posedge clk); #1;
        chipselect = 1'b0; read = 1'b0;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk(t, int'(readdata), int'(e));
        end
    endtask

    task automatic check_regs(input string tag, input int cnt, input int last, input int seen, input int st);
        push_exp({tag, "_count"}, cnt);
        push_exp({tag, "_last"}, last);
        push_exp({tag, "_seen"}, seen);
        push_exp({tag, "_status"}, st);
        for (int a = 0; a < 4; a++) read_check(2'(a));
    endtask

    // Start a frame; optional clear / second start / reset at given cycles.
    // lat = done cycle, -1 on timeout, -2 when reset was applied.
    task automatic run_frame(input int clr_at, input int start_at, input int rst_at, output int lat);
        int cnt;
        cnt = 0;
        lat = -1;
        start = 1'b1;
        while (cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
            start = (cnt == start_at);
            chipselect = (cnt == clr_at);
            write = (cnt == clr_at);
            address = 2'd0;
            if (cnt == rst_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                chk("rst_busy", int'(busy), 0);
                chk("rst_done", int'(done), 0);
                chk("rst_mem_addr", int'(mem_addr), 0);
                chk("rst_readdata", int'(readdata), 0);
                reset = 1'b0;
                lat = -2;
                break;
            end
            if (done) begin
                lat = cnt;
                @(posedge clk); #1;
                chk("done_one_cycle", int'(done), 0);
                break;
            end
        end
        start = 1'b0;
        chipselect = 1'b0;
        write = 1'b0;
    endtask

    initial begin
        int lat;
        int bad;
        int extra;

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_mem_addr", int'(mem_addr), 0);
        chk("reset_readdata", int'(readdata), 0);
        check_regs("reset", 0, 52, 0, 0);

        // Basic frame: class 9 ("10", -1)
        set_frame(-5, 9, 40, -1, 0);
        run_frame(0, 0, 0, lat);
        chk("latency_a", lat, 56);
        check_regs("frame_a", -1, 9, 1, 1);

        // Same card persisting, then background, then the card again
        run_frame(0, 0, 0, lat);
        check_regs("repeat_a", -1, 9, 1, 1);
        set_frame(-5, 52, 50, -1, 0);
        run_frame(0, 0, 0, lat);
        check_regs("background", -1, 52, 1, 1);
        set_frame(-5, 9, 40, -1, 0);
        run_frame(0, 0, 0, lat);
        check_regs("again_a", -2, 9, 2, 1);

        // Tie keeps lowest index (class 3, +1)
        set_frame(-5, 3, 30, 20, 30);
        run_frame(0, 0, 0, lat);
        check_regs("tie", -1, 3, 3, 1);

        // Writes to address 1 are ignored; address 0 clears
        bus_write(2'd1, 8'd5);
        check_regs("wr_ignored", -1, 3, 3, 1);
        bus_write(2'd0, 8'hA5);
        check_regs("clear", 0, 52, 0, 0);

        // Positive saturation with alternating +1 cards
        bad = 0;
        for (int i = 0; i < 130; i++) begin
            set_frame(-5, (i % 2 == 1) ? 14 : 1, 40, -1, 0);
            run_frame(0, 0, 0, lat);
            if (lat != 56) bad++;
        end
        chk("sat_pos_latency_bad", bad, 0);
        check_regs("sat_pos", 127, 14, 130, 1);

        // Negative saturation with alternating Aces
        bus_write(2'd0, 8'h00);
        bad = 0;
        for (int i = 0; i < 130; i++) begin
            set_frame(-5, (i % 2 == 1) ? 13 : 0, 40, -1, 0);
            run_frame(0, 0, 0, lat);
            if (lat != 56) bad++;
        end
        chk("sat_neg_latency_bad", bad, 0);
        check_regs("sat_neg", -128, 13, 130, 1);

        // Clear in the UPDATE cycle wins; done still pulses
        bus_write(2'd0, 8'h00);
        set_frame(-5, 1, 40, -1, 0);
        run_frame(55, 0, 0, lat);
        chk("latency_clear", lat, 56);
        check_regs("clear_update", 0, 52, 0, 0);

        // Start during SCAN is ignored
        set_frame(-5, 9, 40, -1, 0);
        run_frame(0, 10, 0, lat);
        chk("latency_restart", lat, 56);
        extra = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (done || busy) extra++;
        end
        chk("no_second_frame", extra, 0);
        check_regs("restart", -1, 9, 1, 1);

        // Reset in the middle of a scan
        set_frame(-5, 1, 40, -1, 0);
        run_frame(0, 0, 20, lat);
        chk("reset_taken", lat, -2);
        check_regs("mid_reset", 0, 52, 0, 0);

        // Low-confidence winner (score 10)
        set_frame(-5, 5, 10, -1, 0);
        run_frame(0, 0, 0, lat);
        chk("latency_conf", lat, 56);
`ifdef CARD_COUNTER_CONF_EN
        check_regs("low_conf", 0, 52, 0, 1);
`else
        check_regs("low_conf", 1, 5, 1, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
